i2c_target: RTL

- I2C target (slave) endpoint; the responder counterpart to the SoC's i2c_master, used as an on-chip peripheral model and as an external-bus target.
- Runs on the core clock and oversamples SCL/SDA; open-drain SDA is modelled as sda_in plus a drive-low enable.
- Supports 7-bit addressing, multi-byte write and read, repeated START, and no clock stretching.

---
 rtl/i2c_pkg.sv | 28 ++
 rtl/i2c_sync_edge.sv | 59 +++++
 rtl/i2c_target.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_pkg
// Purpose  : Shared types and constants for the I2C target endpoint.
//            state_t enumerates the protocol FSM states; the constants name
//            the bus-level meaning of ACK/NACK and the R/W address bit.
// Revision : 1.0 - initial release
// ============================================================================
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WRITE     = 3'd3,
    WRITE_ACK = 3'd4,
    READ      = 3'd5,
    READ_ACK  = 3'd6,
    WAIT_STOP = 3'd7
  } state_t;

  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/i2c_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : i2c_sync_edge
// Purpose  : Synchronises the asynchronous SCL/SDA lines into the core clock
//            domain and derives SCL edges plus START/STOP conditions.
// Ports    : clk, reset (sync, active-low)
//            scl_in, sda_in       - raw bus levels
//            scl, sda             - synchronised levels
//            scl_rise, scl_fall   - one-cycle SCL edge strobes
//            start_det, stop_det  - one-cycle START / STOP strobes
// Revision : 1.0 - initial release
// ============================================================================
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;

  // Reset to the idle-bus level (both high) so leaving reset on an idle bus
  // produces no spurious edges or START/STOP.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl       = scl_sync[SYNC_STAGES-1];
  assign sda       = sda_sync[SYNC_STAGES-1];
  assign scl_rise  =  scl & ~scl_d;
  assign scl_fall  = ~scl &  scl_d;
  // SCL must be high on both samples so an SDA change coincident with an SCL
  // edge is never mistaken for START/STOP.
  assign start_det = scl & scl_d &  sda_d & ~sda;
  assign stop_det  = scl & scl_d & ~sda_d &  sda;

endmodule
`default_nettype wire

// File: rtl/i2c_target.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target
// Purpose  : I2C target (slave) endpoint with 7-bit addressing, multi-byte
//            write/read and repeated START; no clock stretching. SCL/SDA are
//            oversampled on the core clock; SDA is open-drain via sda_oe.
// Ports    : clk, reset (sync, active-low)
//            scl_in, sda_in  - bus levels (async)
//            sda_oe          - 1 pulls SDA low
//            rx_data/rx_valid- last written byte / one-cycle strobe
//            tx_data/tx_req  - read byte / capture strobe (same cycle)
//            busy            - addressed transaction in progress
//            bus_err         - START/STOP seen mid-byte
// Revision : 1.0 - initial release
// ============================================================================
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic       bus_err
);

  logic       sda;
  logic       scl;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       rw;
  logic       addr_hit;   // address matched; ACK starts on next SCL fall
  logic       ack_bit;    // master's ACK/NACK after a read byte
  logic [7:0] next_byte;
  logic       mid_byte;
  logic       load_tx;

  i2c_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl       (scl),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign next_byte = {shift[6:0], sda};
  assign mid_byte  = ((state == ADDR) || (state == WRITE) || (state == READ)) &&
                     (bit_cnt != 3'd0);

  // tx_req is decoded rather than registered so that the strobe coincides with
  // the clock edge at which tx_data is loaded into the shifter.
  always_comb begin
    load_tx = 1'b0;
    if (reset && scl_fall && !start_det && !stop_det) begin
      if ((state == ADDR_ACK) && (rw == I2C_RW_READ))
        load_tx = 1'b1;
      if ((state == READ_ACK) && (ack_bit == I2C_ACK))
        load_tx = 1'b1;
    end
  end
  assign tx_req = load_tx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      shift    <= 8'd0;
      rw       <= I2C_RW_WRITE;
      addr_hit <= 1'b0;
      ack_bit  <= I2C_NACK;
      sda_oe   <= 1'b0;
      rx_data  <= 8'd0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      bus_err  <= 1'b0;
      if (start_det || stop_det) begin
        // Bus conditions win over any coincident SCL edge.
        bus_err  <= mid_byte;
        sda_oe   <= 1'b0;
        bit_cnt  <= 3'd0;
        addr_hit <= 1'b0;
        if (start_det) begin
          state <= ADDR;      // busy holds across a repeated START
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: ;
          ADDR: begin
            if (scl_rise) begin
              shift   <= next_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (next_byte[7:1] == TARGET_ADDR) begin
                  addr_hit <= 1'b1;
                  rw       <= next_byte[0];
                end else begin
                  state <= WAIT_STOP;
                  busy  <= 1'b0;
                end
              end
            end else if (scl_fall && addr_hit) begin
              addr_hit <= 1'b0;
              sda_oe   <= 1'b1;
              busy     <= 1'b1;
              state    <= ADDR_ACK;
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (rw == I2C_RW_READ) begin
                shift  <= {tx_data[6:0], 1'b0};
                sda_oe <= ~tx_data[7];
                state  <= READ;
              end else begin
                sda_oe <= 1'b0;
                state  <= WRITE;
              end
            end
          end
          WRITE: begin
            if (scl_rise) begin
              shift   <= next_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data  <= next_byte;
                rx_valid <= 1'b1;
              end
            end else if (scl_fall && (bit_cnt == 3'd0)) begin
              // Counter has wrapped: all 8 bits taken, ACK the byte.
              sda_oe <= 1'b1;
              state  <= WRITE_ACK;
            end
          end
          WRITE_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              state  <= WRITE;
            end
          end
          READ: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 3'd0) begin
                sda_oe <= 1'b0;
                state  <= READ_ACK;
              end else begin
                sda_oe <= ~shift[7];
                shift  <= {shift[6:0], 1'b0};
              end
            end
          end
          READ_ACK: begin
            if (scl_rise) begin
              ack_bit <= sda;
            end else if (scl_fall) begin
              if (ack_bit == I2C_ACK) begin
                shift  <= {tx_data[6:0], 1'b0};
                sda_oe <= ~tx_data[7];
                state  <= READ;
              end else begin
                sda_oe <= 1'b0;
                state  <= WAIT_STOP;
              end
            end
          end
          WAIT_STOP: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
